// File: rtl/axi4_pkg.sv
// Shared AXI4 response codes and slave FSM states.
package axi4_pkg;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic [2:0] {
    IDLE,
    WR_DATA,
    WR_RESP,
    RD_ISSUE,
    RD_DATA
  } state_e;

endpackage

// File: rtl/axi4_mem_slave_if.sv
// AXI4 subset (full-width INCR only) between a master and axi4_mem_slave.
interface axi4_mem_slave_if #(
  parameter int unsigned ADDR_WIDTH = 12,
  parameter int unsigned DATA_WIDTH = 32
);

  logic [ADDR_WIDTH-1:0] awaddr;
  logic [7:0]            awlen;
  logic                  awvalid;
  logic                  awready;
  logic [DATA_WIDTH-1:0] wdata;
  logic                  wlast;
  logic                  wvalid;
  logic                  wready;
  logic [1:0]            bresp;
  logic                  bvalid;
  logic                  bready;
  logic [ADDR_WIDTH-1:0] araddr;
  logic [7:0]            arlen;
  logic                  arvalid;
  logic                  arready;
  logic [DATA_WIDTH-1:0] rdata;
  logic [1:0]            rresp;
  logic                  rlast;
  logic                  rvalid;
  logic                  rready;

  modport slave (
    input  awaddr, awlen, awvalid, output awready,
    input  wdata, wlast, wvalid,   output wready,
    output bresp, bvalid,          input  bready,
    input  araddr, arlen, arvalid, output arready,
    output rdata, rresp, rlast, rvalid,
    input  rready
  );

  modport master (
    output awaddr, awlen, awvalid, input  awready,
    output wdata, wlast, wvalid,   input  wready,
    input  bresp, bvalid,          output bready,
    output araddr, arlen, arvalid, input  arready,
    input  rdata, rresp, rlast, rvalid,
    output rready
  );

endinterface

// File: rtl/axi4_mem_slave.sv
// AXI4 slave front-end for a single-port synchronous memory (1-cycle read latency).
// One transaction at a time, round-robin between read and write.
module axi4_mem_slave
  import axi4_pkg::*;
#(
  parameter int unsigned DATA_WIDTH     = 32,
  parameter int unsigned ADDR_WIDTH     = 12,
  parameter int unsigned MEM_ADDR_WIDTH = 10,
  parameter int unsigned DEPTH          = 1024
) (
  input  logic                      clk,
  input  logic                      rst_n,
  axi4_mem_slave_if.slave           axi,
  output logic                      mem_en,
  output logic                      mem_we,
  output logic [MEM_ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0]     mem_wdata,
  input  logic [DATA_WIDTH-1:0]     mem_rdata
);

  localparam int unsigned WORD_W = ADDR_WIDTH - 2;
  // Wide enough for start word + 255 beats without wrapping.
  localparam int unsigned BEAT_W = WORD_W + 9;

  state_e              state_q, state_d;
  logic                prio_wr_q;
  logic [WORD_W-1:0]   start_word_q;
  logic                misalign_q;
  logic [7:0]          len_q;
  logic [7:0]          beat_q;
  logic                err_q;

  logic [BEAT_W-1:0]   beat_word;
  logic                beat_legal;
  logic                last_beat;
  logic                grant_wr;
  logic                grant_rd;

  // Untruncated beat address, legality and arbitration.
  always_comb begin
    beat_word  = BEAT_W'(start_word_q) + BEAT_W'(beat_q);
    beat_legal = !misalign_q && (beat_word < BEAT_W'(DEPTH));
    last_beat  = (beat_q == len_q);
    grant_wr   = axi.awvalid && (!axi.arvalid || prio_wr_q);
    grant_rd   = axi.arvalid && !grant_wr;
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next-state and handshake/memory strobes.
  always_comb begin
    state_d     = state_q;
    axi.awready = 1'b0;
    axi.arready = 1'b0;
    axi.wready  = 1'b0;
    axi.bvalid  = 1'b0;
    axi.bresp   = RESP_OKAY;
    axi.rvalid  = 1'b0;
    axi.rlast   = 1'b0;
    axi.rresp   = RESP_OKAY;
    axi.rdata   = '0;
    mem_en      = 1'b0;
    mem_we      = 1'b0;
    mem_addr    = MEM_ADDR_WIDTH'(beat_word);
    mem_wdata   = axi.wdata;
    case (state_q)
      IDLE: begin
        if (grant_wr) begin
          axi.awready = 1'b1;
          state_d     = WR_DATA;
        end else if (grant_rd) begin
          axi.arready = 1'b1;
          state_d     = RD_ISSUE;
        end
      end
      WR_DATA: begin
        axi.wready = 1'b1;
        if (axi.wvalid) begin
          mem_en = beat_legal;
          mem_we = beat_legal;
          if (last_beat) state_d = WR_RESP;
        end
      end
      WR_RESP: begin
        axi.bvalid = 1'b1;
        axi.bresp  = err_q ? RESP_SLVERR : RESP_OKAY;
        if (axi.bready) state_d = IDLE;
      end
      RD_ISSUE: begin
        mem_en  = beat_legal;
        state_d = RD_DATA;
      end
      RD_DATA: begin
        axi.rvalid = 1'b1;
        axi.rlast  = last_beat;
        axi.rresp  = beat_legal ? RESP_OKAY : RESP_SLVERR;
        axi.rdata  = beat_legal ? mem_rdata : '0;
        if (axi.rready) state_d = last_beat ? IDLE : RD_ISSUE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Burst context: start word, length, beat counter, error flag, priority pointer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prio_wr_q    <= 1'b1;
      start_word_q <= '0;
      misalign_q   <= 1'b0;
      len_q        <= '0;
      beat_q       <= '0;
      err_q        <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (grant_wr) begin
            start_word_q <= axi.awaddr[ADDR_WIDTH-1:2];
            misalign_q   <= |axi.awaddr[1:0];
            len_q        <= axi.awlen;
            beat_q       <= '0;
            err_q        <= 1'b0;
            prio_wr_q    <= 1'b0;
          end else if (grant_rd) begin
            start_word_q <= axi.araddr[ADDR_WIDTH-1:2];
            misalign_q   <= |axi.araddr[1:0];
            len_q        <= axi.arlen;
            beat_q       <= '0;
            err_q        <= 1'b0;
            prio_wr_q    <= 1'b1;
          end
        end
        WR_DATA: begin
          if (axi.wvalid) begin
            beat_q <= beat_q + 8'd1;
            if (!beat_legal || (axi.wlast != last_beat)) err_q <= 1'b1;
          end
        end
        WR_RESP: begin
          if (axi.bready) err_q <= 1'b0;
        end
        RD_DATA: begin
          if (axi.rready && !last_beat) beat_q <= beat_q + 8'd1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_axi4_mem_slave.sv
// Bench for axi4_mem_slave: directed plan steps plus randomized bursts,
// checked against a word-array model of the memory and AXI response rules.
module tb_axi4_mem_slave;
  import axi4_pkg::*;

  localparam int unsigned DW    = 32;
  localparam int unsigned AW    = 12;
  localparam int unsigned MAW   = 10;
  localparam int unsigned DEPTH = 1024;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  axi4_mem_slave_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) axi ();

  logic           mem_en;
  logic           mem_we;
  logic [MAW-1:0] mem_addr;
  logic [DW-1:0]  mem_wdata;
  logic [DW-1:0]  mem_rdata;

  axi4_mem_slave #(
    .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .MEM_ADDR_WIDTH(MAW), .DEPTH(DEPTH)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .axi      (axi),
    .mem_en   (mem_en),
    .mem_we   (mem_we),
    .mem_addr (mem_addr),
    .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata)
  );

  // Synchronous single-port memory, one-cycle read latency.
  logic [DW-1:0] mem [DEPTH];
  always @(posedge clk) begin
    if (mem_en) begin
      if (mem_we) mem[mem_addr] <= mem_wdata;
      else        mem_rdata     <= mem[mem_addr];
    end
  end

  // Strobe monitor, sampled mid low-phase.
  int wr_en_cnt = 0;
  int rd_en_cnt = 0;
  always @(negedge clk) begin
    #2;
    if (mem_en === 1'b1) begin
      if (mem_we === 1'b1) wr_en_cnt++;
      else                 rd_en_cnt++;
    end
  end

  // Reference memory contents; ref_known marks words the bench has written.
  logic [DW-1:0] ref_mem   [DEPTH];
  bit            ref_known [DEPTH];
  logic [DW-1:0] wbuf      [256];

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic bit beat_ok(input logic [AW-1:0] addr, input int i);
    int word;
    word = int'(addr >> 2) + i;
    return (addr[1:0] == 2'b00) && (word < int'(DEPTH));
  endfunction

  // Apply a write burst to the model; returns expected bresp and legal-beat count.
  task automatic model_write(input logic [AW-1:0] addr, input logic [7:0] len,
                             input int bad_beat, output logic [1:0] resp, output int cnt);
    bit err;
    int word;
    err = 1'b0;
    cnt = 0;
    for (int i = 0; i <= int'(len); i++) begin
      word = int'(addr >> 2) + i;
      if (beat_ok(addr, i)) begin
        ref_mem[word]   = wbuf[i];
        ref_known[word] = 1'b1;
        cnt++;
      end else begin
        err = 1'b1;
      end
      if (i == bad_beat) err = 1'b1;
    end
    resp = err ? RESP_SLVERR : RESP_OKAY;
  endtask

  task automatic aw_handshake(input logic [AW-1:0] addr, input logic [7:0] len);
    @(negedge clk);
    axi.awaddr  = addr;
    axi.awlen   = len;
    axi.awvalid = 1'b1;
    #1;
    for (int n = 0; n < 50 && axi.awready !== 1'b1; n++) begin @(negedge clk); #1; end
    check("awready", 32'(axi.awready), 32'd1);
    @(negedge clk);
    axi.awvalid = 1'b0;
  endtask

  task automatic ar_handshake(input logic [AW-1:0] addr, input logic [7:0] len);
    @(negedge clk);
    axi.araddr  = addr;
    axi.arlen   = len;
    axi.arvalid = 1'b1;
    #1;
    for (int n = 0; n < 50 && axi.arready !== 1'b1; n++) begin @(negedge clk); #1; end
    check("arready", 32'(axi.arready), 32'd1);
    @(negedge clk);
    axi.arvalid = 1'b0;
  endtask

  // Drive len+1 write beats from wbuf; wlast is inverted on bad_beat.
  task automatic w_beats(input logic [7:0] len, input int bad_beat);
    for (int i = 0; i <= int'(len); i++) begin
      axi.wdata  = wbuf[i];
      axi.wlast  = (i == int'(len)) ^ (i == bad_beat);
      axi.wvalid = 1'b1;
      #1;
      for (int n = 0; n < 50 && axi.wready !== 1'b1; n++) begin @(negedge clk); #1; end
      check("wready", 32'(axi.wready), 32'd1);
      @(negedge clk);
    end
    axi.wvalid = 1'b0;
    axi.wlast  = 1'b0;
  endtask

  task automatic b_phase(input logic [1:0] exp_resp, input int stall);
    axi.bready = 1'b0;
    #1;
    for (int n = 0; n < 50 && axi.bvalid !== 1'b1; n++) begin @(negedge clk); #1; end
    check("bvalid", 32'(axi.bvalid), 32'd1);
    repeat (stall) begin
      check("bresp_stalled", 32'(axi.bresp), 32'(exp_resp));
      @(negedge clk); #1;
    end
    check("bresp", 32'(axi.bresp), 32'(exp_resp));
    axi.bready = 1'b1;
    @(negedge clk);
    axi.bready = 1'b0;
  endtask

  // Collect len+1 read beats; with toggle, rready is held low for random stalls.
  task automatic r_beats(input logic [AW-1:0] addr, input logic [7:0] len, input bit toggle);
    bit            legal, known;
    int            word, stall;
    logic [DW-1:0] exp_data;
    for (int i = 0; i <= int'(len); i++) begin
      word     = int'(addr >> 2) + i;
      legal    = beat_ok(addr, i);
      known    = !legal || ref_known[word];
      exp_data = legal ? ref_mem[word] : '0;
      axi.rready = 1'b0;
      #1;
      for (int n = 0; n < 50 && axi.rvalid !== 1'b1; n++) begin @(negedge clk); #1; end
      check("rvalid", 32'(axi.rvalid), 32'd1);
      stall = toggle ? int'($urandom_range(1, 3)) : 0;
      repeat (stall) begin
        if (known) check("rdata_stalled", axi.rdata, exp_data);
        check("rvalid_stalled", 32'(axi.rvalid), 32'd1);
        @(negedge clk); #1;
      end
      if (known) check("rdata", axi.rdata, exp_data);
      check("rresp", 32'(axi.rresp), legal ? 32'(RESP_OKAY) : 32'(RESP_SLVERR));
      check("rlast", 32'(axi.rlast), 32'(i == int'(len)));
      axi.rready = 1'b1;
      @(negedge clk);
      axi.rready = 1'b0;
    end
  endtask

  task automatic write_txn(input logic [AW-1:0] addr, input logic [7:0] len,
                           input int bad_beat, input int stall);
    logic [1:0] resp;
    int         cnt, base;
    model_write(addr, len, bad_beat, resp, cnt);
    base = wr_en_cnt;
    aw_handshake(addr, len);
    w_beats(len, bad_beat);
    check("wr_strobes", 32'(wr_en_cnt - base), 32'(cnt));
    b_phase(resp, stall);
  endtask

  task automatic read_txn(input logic [AW-1:0] addr, input logic [7:0] len, input bit toggle);
    int cnt, base;
    cnt = 0;
    for (int i = 0; i <= int'(len); i++) if (beat_ok(addr, i)) cnt++;
    base = rd_en_cnt;
    ar_handshake(addr, len);
    r_beats(addr, len, toggle);
    check("rd_strobes", 32'(rd_en_cnt - base), 32'(cnt));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired observed=running expected=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [1:0] resp;
    int         cnt, base;
    logic [AW-1:0] a;
    logic [7:0]    l;

    rst_n       = 1'b0;
    axi.awaddr  = '0; axi.awlen = '0; axi.awvalid = 1'b0;
    axi.wdata   = '0; axi.wlast = 1'b0; axi.wvalid = 1'b0;
    axi.bready  = 1'b0;
    axi.araddr  = '0; axi.arlen = '0; axi.arvalid = 1'b0;
    axi.rready  = 1'b0;

    // Reset values
    #3;
    check("rst_awready", 32'(axi.awready), 32'd0);
    check("rst_arready", 32'(axi.arready), 32'd0);
    check("rst_wready",  32'(axi.wready),  32'd0);
    check("rst_bvalid",  32'(axi.bvalid),  32'd0);
    check("rst_rvalid",  32'(axi.rvalid),  32'd0);
    check("rst_rlast",   32'(axi.rlast),   32'd0);
    check("rst_bresp",   32'(axi.bresp),   32'd0);
    check("rst_rresp",   32'(axi.rresp),   32'd0);
    check("rst_mem_en",  32'(mem_en),      32'd0);
    check("rst_mem_we",  32'(mem_we),      32'd0);
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Contention straight after reset: write first, then alternate.
    wbuf[0] = 32'hDEADBEEF;
    model_write(12'h010, 8'd0, -1, resp, cnt);
    base = wr_en_cnt;
    axi.awaddr = 12'h010; axi.awlen = 8'd0; axi.awvalid = 1'b1;
    axi.araddr = 12'h010; axi.arlen = 8'd0; axi.arvalid = 1'b1;
    #1;
    check("arb0_awready", 32'(axi.awready), 32'd1);
    check("arb0_arready", 32'(axi.arready), 32'd0);
    @(negedge clk);
    axi.awvalid = 1'b0;
    w_beats(8'd0, -1);
    check("arb0_wr_strobes", 32'(wr_en_cnt - base), 32'(cnt));
    b_phase(resp, 1);

    wbuf[0] = 32'h12345678;
    model_write(12'h020, 8'd0, -1, resp, cnt);
    axi.awaddr = 12'h020; axi.awlen = 8'd0; axi.awvalid = 1'b1;
    #1;
    check("arb1_arready", 32'(axi.arready), 32'd1);
    check("arb1_awready", 32'(axi.awready), 32'd0);
    @(negedge clk);
    axi.arvalid = 1'b0;
    r_beats(12'h010, 8'd0, 1'b0);

    axi.araddr = 12'h020; axi.arlen = 8'd0; axi.arvalid = 1'b1;
    #1;
    check("arb2_awready", 32'(axi.awready), 32'd1);
    check("arb2_arready", 32'(axi.arready), 32'd0);
    @(negedge clk);
    axi.awvalid = 1'b0;
    base = wr_en_cnt;
    w_beats(8'd0, -1);
    check("arb2_wr_strobes", 32'(wr_en_cnt - base), 32'(cnt));
    b_phase(resp, 0);
    #1;
    check("arb3_arready", 32'(axi.arready), 32'd1);
    @(negedge clk);
    axi.arvalid = 1'b0;
    r_beats(12'h020, 8'd0, 1'b0);

    // Four-beat burst, read back with rready stalls.
    for (int i = 0; i < 4; i++) wbuf[i] = 32'(i + 1);
    write_txn(12'h100, 8'd3, -1, 0);
    read_txn(12'h100, 8'd3, 1'b1);

    // Burst running past the last word.
    for (int i = 0; i < 4; i++) wbuf[i] = $urandom;
    write_txn(12'hFF8, 8'd3, -1, 2);
    read_txn(12'hFF8, 8'd3, 1'b1);

    // Early wlast, then a misaligned read.
    wbuf[0] = 32'hA5A5_0001; wbuf[1] = 32'hA5A5_0002;
    write_txn(12'h200, 8'd1, 0, 0);
    read_txn(12'h200, 8'd1, 1'b0);
    read_txn(12'h002, 8'd0, 1'b0);

    // Randomized traffic.
    for (int t = 0; t < 24; t++) begin
      a = AW'($urandom_range(0, 4095));
      if ($urandom_range(0, 9) != 0) a[1:0] = 2'b00;
      l = 8'($urandom_range(0, 7));
      if ($urandom_range(0, 1) == 1) begin
        for (int i = 0; i <= int'(l); i++) wbuf[i] = $urandom;
        write_txn(a, l, -1, int'($urandom_range(0, 2)));
      end else begin
        read_txn(a, l, 1'($urandom_range(0, 1)));
      end
    end

    // Reset while a read beat is outstanding.
    ar_handshake(12'h100, 8'd3);
    #1;
    for (int n = 0; n < 50 && axi.rvalid !== 1'b1; n++) begin @(negedge clk); #1; end
    check("rstmid_rvalid_before", 32'(axi.rvalid), 32'd1);
    rst_n = 1'b0;
    #1;
    check("rstmid_rvalid", 32'(axi.rvalid), 32'd0);
    check("rstmid_rlast",  32'(axi.rlast),  32'd0);
    check("rstmid_mem_en", 32'(mem_en),     32'd0);
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;
    wbuf[0] = 32'hC0FFEE11;
    write_txn(12'h040, 8'd0, -1, 0);
    read_txn(12'h040, 8'd0, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
